// File: rtl/train_state_timer.sv
// train_state_timer: multi-channel dwell timer driven by the train controller FSM.
// Each channel reloads from load_val whenever present_state changes or its own
// restart bit is set. It then counts down once per clock and reports expiry as a
// done level and a one-cycle expire pulse. A channel runs one-shot or periodic,
// and a global pause holds every counting channel.
module train_state_timer #(
    parameter int WIDTH    = 19,
    parameter int CHANNELS = 4,
    parameter int STATE_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [STATE_W-1:0]        present_state,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS-1:0]       restart,
    input  logic                      pause,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expire,
    output logic [CHANNELS*WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    ch_state_e           state_r     [CHANNELS];
    ch_state_e           state_nxt_s [CHANNELS];
    logic [WIDTH-1:0]    count_r     [CHANNELS];
    logic [WIDTH-1:0]    count_nxt_s [CHANNELS];
    logic [WIDTH-1:0]    load_s      [CHANNELS];
    logic [CHANNELS-1:0] done_r;
    logic [CHANNELS-1:0] done_nxt_s;
    logic [CHANNELS-1:0] expire_r;
    logic [CHANNELS-1:0] expire_nxt_s;
    logic [STATE_W-1:0]  prev_state_r;
    logic                state_chg_s;
    logic [CHANNELS-1:0] trig_s;

    // Reload trigger: any controller state change plus each channel's own restart.
    always_comb begin
        state_chg_s = (present_state != prev_state_r);
        trig_s      = {CHANNELS{state_chg_s}} | restart;
    end

    // Split the packed reload bus into one value per channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            load_s[i] = load_val[i*WIDTH +: WIDTH];
        end
    end

    // Per-channel next state. Priority: disable > trigger > pause > decrement.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_nxt_s[i]  = state_r[i];
            count_nxt_s[i]  = count_r[i];
            expire_nxt_s[i] = 1'b0;
            if (!enable[i]) begin
                state_nxt_s[i] = ST_IDLE;
                count_nxt_s[i] = '0;
            end else if (trig_s[i]) begin
                // A reload wins over pause and over a coincident expiry.
                count_nxt_s[i] = load_s[i];
                if (load_s[i] == '0) begin
                    state_nxt_s[i]  = ST_DONE;
                    expire_nxt_s[i] = 1'b1;
                end else begin
                    state_nxt_s[i] = ST_RUN;
                end
            end else begin
                case (state_r[i])
                    ST_RUN: begin
                        if (pause) begin
                            count_nxt_s[i] = count_r[i];
                        end else if (count_r[i] > WIDTH'(1)) begin
                            count_nxt_s[i] = count_r[i] - WIDTH'(1);
                        end else begin
                            // Terminal count. A periodic channel picks up the
                            // current load_val. A zero load_val parks it in DONE.
                            expire_nxt_s[i] = 1'b1;
                            if (periodic[i] && (load_s[i] != '0)) begin
                                count_nxt_s[i] = load_s[i];
                                state_nxt_s[i] = ST_RUN;
                            end else begin
                                count_nxt_s[i] = '0;
                                state_nxt_s[i] = ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        count_nxt_s[i] = '0;
                        state_nxt_s[i] = ST_DONE;
                    end
                    ST_IDLE: begin
                        count_nxt_s[i] = '0;
                        state_nxt_s[i] = ST_IDLE;
                    end
                    default: begin
                        count_nxt_s[i] = '0;
                        state_nxt_s[i] = ST_IDLE;
                    end
                endcase
            end
            done_nxt_s[i] = (state_nxt_s[i] == ST_DONE);
        end
    end

    // State, counters and registered outputs. prev_state tracks its input even
    // during reset, so no trigger fires on the first cycle after reset.
    always_ff @(posedge clk) begin
        prev_state_r <= present_state;
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i] <= ST_IDLE;
                count_r[i] <= '0;
            end
            done_r   <= '0;
            expire_r <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i] <= state_nxt_s[i];
                count_r[i] <= count_nxt_s[i];
            end
            done_r   <= done_nxt_s;
            expire_r <= expire_nxt_s;
        end
    end

    assign done   = done_r;
    assign expire = expire_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = count_r[g];
    end

endmodule

// File: tb/tb_train_state_timer.sv
// Scoreboard bench for train_state_timer. Stimulus pushes expected
// (edge, channel, done, expire, count) records. A negedge monitor pops and
// compares the records that fall due on each clock edge.
module tb_train_state_timer;

    localparam int W = 19;
    localparam int C = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [S-1:0]   present_state;
    logic [C*W-1:0] load_val;
    logic [C-1:0]   enable;
    logic [C-1:0]   periodic;
    logic [C-1:0]   restart;
    logic           pause;
    logic [C-1:0]   done;
    logic [C-1:0]   expire;
    logic [C*W-1:0] count;

    train_state_timer #(.WIDTH(W), .CHANNELS(C), .STATE_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .present_state(present_state),
        .load_val(load_val), .enable(enable), .periodic(periodic),
        .restart(restart), .pause(pause), .done(done), .expire(expire),
        .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    at;
        int    ch;
        bit    d;
        bit    e;
        int    cnt;
        string nm;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare every record that falls due on this edge. A record whose
    // edge has already passed counts as a missed check.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                checks++;
                if (done[sb_q[i].ch] !== sb_q[i].d || expire[sb_q[i].ch] !== sb_q[i].e ||
                    count[sb_q[i].ch*W +: W] !== W'(sb_q[i].cnt)) begin
                    errors++;
                    $display("FAIL %s edge %0d ch%0d: got done=%b expire=%b count=%0d, want done=%b expire=%b count=%0d",
                             sb_q[i].nm, cyc, sb_q[i].ch, done[sb_q[i].ch], expire[sb_q[i].ch],
                             count[sb_q[i].ch*W +: W], sb_q[i].d, sb_q[i].e, sb_q[i].cnt);
                end
                sb_q.delete(i);
            end else if (sb_q[i].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: record for edge %0d missed, now edge %0d", sb_q[i].nm, sb_q[i].at, cyc);
                sb_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ex(input int at, input int ch, input bit d, input bit e, input int cnt, input string nm);
        exp_t r;
        r.at = at; r.ch = ch; r.d = d; r.e = e; r.cnt = cnt; r.nm = nm;
        sb_q.push_back(r);
    endtask

    task automatic set_ld(input int ch, input int v);
        logic [31:0] tmp;
        tmp = v;
        load_val[ch*W +: W] = tmp[W-1:0];
    endtask

    int k;
    int m;

    initial begin
        rst_n = 1'b0; present_state = '0; load_val = '0; enable = '0;
        periodic = '0; restart = '0; pause = 1'b0;

        // Reset state.
        for (int ch = 0; ch < C; ch++) begin
            ex(1, ch, 1'b0, 1'b0, 0, "reset");
            ex(2, ch, 1'b0, 1'b0, 0, "reset");
        end
        tick(); tick();

        // Enabling without a trigger leaves the channel idle.
        rst_n = 1'b1; enable = '1;
        set_ld(0, 5); set_ld(1, 3); set_ld(2, 100); set_ld(3, 100);
        ex(cyc + 1, 0, 1'b0, 1'b0, 0, "idle_no_trig");
        tick();

        // One-shot L=5 started by a present_state change.
        present_state = 4'd1;
        k = cyc + 1;
        for (int j = 0; j < 5; j++) ex(k + j, 0, 1'b0, 1'b0, 5 - j, "oneshot5");
        ex(k + 5, 0, 1'b1, 1'b1, 0, "oneshot5_expire");
        ex(k + 6, 0, 1'b1, 1'b0, 0, "oneshot5_done_hold");
        tick();
        repeat (7) tick();

        // Periodic L=3 on ch1: expire every 3 cycles, done stays low.
        periodic = 4'b0010; restart = 4'b0010;
        k = cyc + 1;
        for (int j = 0; j <= 12; j++)
            ex(k + j, 1, 1'b0, (j > 0) && (j % 3 == 0), 3 - (j % 3), "periodic3");
        tick();
        restart = '0;
        repeat (12) tick();
        enable[1] = 1'b0;
        ex(cyc + 1, 1, 1'b0, 1'b0, 0, "disable_run");
        tick();

        // L=10 with four paused edges: expiry at 14.
        set_ld(0, 10); restart = 4'b0001;
        k = cyc + 1;
        for (int j = 0; j <= 2; j++) ex(k + j, 0, 1'b0, 1'b0, 10 - j, "pause_pre");
        for (int j = 3; j <= 6; j++) ex(k + j, 0, 1'b0, 1'b0, 8, "pause_hold");
        for (int j = 7; j <= 13; j++) ex(k + j, 0, 1'b0, 1'b0, 14 - j, "pause_post");
        ex(k + 14, 0, 1'b1, 1'b1, 0, "pause_expire");
        tick();
        restart = '0;
        tick(); tick();
        pause = 1'b1;
        repeat (4) tick();
        pause = 1'b0;
        repeat (8) tick();

        // Restart at count==1: the reload wins and no pulse is produced.
        restart = 4'b0001;
        k = cyc + 1;
        ex(k, 0, 1'b0, 1'b0, 10, "rst1_load");
        ex(k + 9, 0, 1'b0, 1'b0, 1, "rst1_at1");
        ex(k + 10, 0, 1'b0, 1'b0, 10, "rst1_reload_nopulse");
        ex(k + 11, 0, 1'b0, 1'b0, 9, "rst1_after");
        tick();
        restart = '0;
        repeat (9) tick();
        restart = 4'b0001;
        tick();
        restart = '0;
        tick();

        // load_val=0: one-edge expiry, then disable in DONE and re-enable.
        set_ld(0, 0); restart = 4'b0001;
        k = cyc + 1;
        ex(k, 0, 1'b1, 1'b1, 0, "zero_load");
        ex(k + 1, 0, 1'b1, 1'b0, 0, "zero_load_hold");
        ex(k + 2, 0, 1'b0, 1'b0, 0, "disable_done");
        ex(k + 3, 0, 1'b0, 1'b0, 0, "reenable_idle");
        ex(k + 4, 0, 1'b0, 1'b0, 0, "reenable_idle2");
        tick();
        restart = '0;
        tick();
        enable[0] = 1'b0;
        tick();
        enable[0] = 1'b1;
        tick(); tick();

        // Park ch0 in DONE. A load_val change afterwards has no effect until a reload.
        restart = 4'b0001;
        ex(cyc + 1, 0, 1'b1, 1'b1, 0, "park_done");
        tick();
        restart = '0; set_ld(0, 4);
        ex(cyc + 1, 0, 1'b1, 1'b0, 0, "ld_change_no_effect");
        tick();

        // Independence: ch2 restart while ch3 runs.
        set_ld(2, 6); set_ld(3, 20); restart = 4'b1000;
        k = cyc + 1;
        ex(k, 3, 1'b0, 1'b0, 20, "ch3_load");
        tick();
        restart = '0;
        tick();
        restart = 4'b0100;
        ex(k + 2, 3, 1'b0, 1'b0, 18, "ch3_indep");
        ex(k + 2, 2, 1'b0, 1'b0, 6, "ch2_load");
        ex(k + 3, 3, 1'b0, 1'b0, 17, "ch3_indep2");
        ex(k + 3, 2, 1'b0, 1'b0, 5, "ch2_count");
        tick();
        restart = '0;
        tick();

        // A state change reloads every enabled channel, including ch0 in DONE.
        present_state = 4'd2;
        m = cyc + 1;
        ex(m, 0, 1'b0, 1'b0, 4, "chg_from_done");
        ex(m, 1, 1'b0, 1'b0, 0, "chg_disabled");
        ex(m, 2, 1'b0, 1'b0, 6, "chg_ch2");
        ex(m, 3, 1'b0, 1'b0, 20, "chg_ch3");
        ex(m + 1, 0, 1'b0, 1'b0, 3, "chg_ch0_next");
        ex(m + 1, 3, 1'b0, 1'b0, 19, "chg_ch3_next");
        tick(); tick();

        // Reset during RUN with count=7, then no spurious trigger after release.
        ex(m + 13, 3, 1'b0, 1'b0, 7, "ch3_at7");
        repeat (12) tick();
        rst_n = 1'b0;
        for (int ch = 0; ch < C; ch++) ex(cyc + 1, ch, 1'b0, 1'b0, 0, "reset_mid");
        tick();
        rst_n = 1'b1;
        for (int ch = 0; ch < C; ch++) begin
            ex(cyc + 1, ch, 1'b0, 1'b0, 0, "no_spurious");
            ex(cyc + 2, ch, 1'b0, 1'b0, 0, "no_spurious2");
        end
        tick(); tick();

        // Bounded drain: every remaining record falls due or is reported missed.
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/train_state_timer.md
# train_state_timer

Multi-channel dwell timer for the train controller FSM. Each channel reloads a programmable count whenever `present_state` changes (or on a per-channel restart), counts down one per clock, and signals expiry as a level and a one-cycle pulse. Channels run one-shot or periodic, with global pause, so one block serves door, brake-release and signalling delays. It sits beside the controller FSM, which supplies `present_state` and consumes `done`/`expire`.

## Interface

Parameters:
- `WIDTH`, 19, counter and load-value width per channel
- `CHANNELS`, 4, number of independent timer channels
- `STATE_W`, 4, width of `present_state`

Ports:
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  synchronous reset, active-low
- `present_state`  input  STATE_W  controller FSM state; any change is a reload trigger
- `load_val`  input  CHANNELS*WIDTH  per-channel reload value, channel i at bits [i*WIDTH +: WIDTH]
- `enable`  input  CHANNELS  per-channel enable; low forces channel to IDLE
- `periodic`  input  CHANNELS  per-channel mode: 1 auto-reload, 0 one-shot
- `restart`  input  CHANNELS  per-channel reload trigger, sampled each cycle
- `pause`  input  1  global hold of all counting channels
- `done`  output  CHANNELS  level: channel in DONE state
- `expire`  output  CHANNELS  one-cycle pulse at each expiry
- `count`  output  CHANNELS*WIDTH  current remaining count per channel

## Operation

- Reset is synchronous and active-low: clock `clk`, reset `rst_n`; the polarity and synchronicity are fixed.
- Edge detect: `prev_state` register; `state_chg = (present_state != prev_state)`; `prev_state <= present_state` every cycle. Trigger for channel i: `trig[i] = state_chg | restart[i]`.
- Per-channel FSM, states IDLE, RUN, DONE. Priority per cycle: `!enable[i]` > `trig[i]` > `pause` > decrement.
- Any state, `enable[i]=0`: go IDLE, count=0, done=0, expire=0.
- Any state, enabled and `trig[i]`: count<=load_val. If load_val==0, go DONE and pulse expire. Otherwise go RUN. Pause never blocks a reload.
- RUN, no trig, pause=1: hold count, no pulse.
- RUN, no trig, pause=0, count>1: count<=count-1.
- RUN, no trig, pause=0, count==1: expire pulse.
  - periodic=1: count<=current load_val and stay RUN; if that load_val==0, count=0 and go DONE.
  - periodic=0: count<=0 and go DONE.
- DONE: hold count=0, done=1. Leave only on trig (reload) or disable. Pause has no effect.
- IDLE with enable=1 and no trig: stay IDLE. Enabling a channel does not start it; a trigger is required.
- `load_val` is sampled only at reload instants. Changes mid-count take effect at the next reload.
- Arithmetic is unsigned WIDTH bits. The decrement never occurs at 0, so there is no wrap-around.

## Timing

- Reset values: done=0, expire=0, count=0, all channels IDLE. `prev_state` <= `present_state` during reset, so no trigger fires on the first cycle after reset.
- All outputs are registered. expire and done rise on the same edge.
- Trigger sampled at edge k with load_val=L≥1, no pause: count=L after edge k, count=1 after edge k+L-1, expire=1 and done=1 after edge k+L. Expiry latency is L cycles.
- load_val=0: expire and done after edge k, 1 cycle latency.
- Periodic: expire pulses every L cycles. done stays 0 while periodic with L≥1.
- Each paused cycle extends expiry by exactly one cycle.
- Trigger in the same cycle as count==1: the reload wins and there is no expire pulse.
- Reset asserted mid-count: all channels return to reset values on that edge.

## Test plan

- Reset, enable=all, load_val ch0=5, change present_state 0→1 -> ch0 expire single pulse and done=1 exactly 5 cycles after trigger edge; count sequence 5,4,3,2,1,0.
- ch1 periodic=1, L=3, one trigger -> expire on ch1 every 3 cycles for 12 cycles (4 pulses); done stays 0; count cycles 3,2,1,3,…
- ch0 L=10, pause held 4 cycles mid-count -> expiry at 14 cycles; restart[0] at count==1 -> no pulse, count=10 next cycle.
- load_val=0 with trigger -> expire and done after 1 edge. enable dropped in DONE -> done=0, count=0 next edge. Re-enable without trigger -> stays IDLE.
- Independence: ch2 restart only while ch3 running -> ch3 unaffected. present_state change reloads all enabled channels simultaneously, including the one in DONE.
- rst_n low for one cycle during RUN at count=7 -> all outputs 0 next edge; no spurious trigger after release with present_state steady.
